// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | pipe_hazard_ctrl : stall/flush controller for the 5-stage MIPS32 pipeline.
// | Optional stall performance counter enabled by `define STALL_PERF_EN.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;
  logic       w_freeze;
  logic       w_load_use;

  assign w_freeze = ((r_state == S_RUN) && mem_req && !dmem_ready) ||
                    ((r_state == S_MEM_WAIT) && !dmem_ready) ||
                    (r_state == S_ERR);

  assign w_load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (mem_req && !dmem_ready) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state <= S_RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == c_wait_last) begin
              r_state   <= S_ERR;
              r_mem_err <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign mem_err = r_mem_err;

  // Freeze outranks branch flush and load-use; masked events are re-presented later.
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    if (!reset) begin
      pc_write = 1'b0;
    end else if (w_freeze) begin
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (branch_taken) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
    end else if (w_load_use) begin
      idex_bubble = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (!pc_write && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_pipe_hazard_ctrl : directed + randomized checks of pipe_hazard_ctrl
// | against an access-level reference model. Honours `define STALL_PERF_EN.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  localparam logic [6:0] C_ZERO   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b0001011;
  localparam logic [6:0] C_BRANCH = 7'b1110000;
  localparam logic [6:0] C_LOADU  = 7'b0000100;
  localparam logic [6:0] C_NORMAL = 7'b1100000;

`ifdef STALL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             ex_memread, mem_req, dmem_ready, branch_taken;
  logic             pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble;
  logic             exmem_hold, memwb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [6:0]       ctrl;

  int tests = 0;
  int fails = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
                 exmem_hold, memwb_bubble};

  // Reference model: an access is a run of consecutive unready cycles; the
  // (MEM_TIMEOUT+1)-th such cycle latches the error for good.
  int   m_busy  = 0;
  logic m_err   = 1'b0;
  int   m_stall = 0;
  logic m_frz, m_lu;
  logic [6:0] m_exp;
  logic [CNT_W-1:0] m_stall_exp;

  assign m_frz = m_err || (!dmem_ready && ((m_busy > 0) || mem_req));
  assign m_lu  = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign m_exp = !reset ? C_ZERO : m_frz ? C_FREEZE : branch_taken ? C_BRANCH :
                 m_lu ? C_LOADU : C_NORMAL;
  assign m_stall_exp = (PERF != 0) ? CNT_W'(m_stall) : '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy  <= 0;
      m_err   <= 1'b0;
      m_stall <= 0;
    end else begin
      if (!m_exp[6] && (m_stall < STALL_MAX)) m_stall <= m_stall + 1;
      if (!m_err) begin
        if (m_frz) begin
          m_busy <= m_busy + 1;
          if (m_busy + 1 == MEM_TIMEOUT + 1) m_err <= 1'b1;
        end else begin
          m_busy <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    tests++;
    if (ctrl !== m_exp || mem_err !== m_err || stall_cycles !== m_stall_exp) begin
      fails++;
      $display("FAIL model_cycle t=%0t ctrl=%b req=%b mem_err=%b req=%b stall=%0d req=%0d",
               $time, ctrl, m_exp, mem_err, m_err, stall_cycles, m_stall_exp);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; ex_memread = 1'b0;
    mem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("reset_err", 32'(mem_err), 0);
    chk("reset_stall", 32'(stall_cycles), 0);

    step(); reset = 1'b1; mem_req = 1'b0; branch_taken = 1'b0; dmem_ready = 1'b1;
    @(negedge clk); chk("release_pc_ifid", 32'({pc_write, ifid_write}), 3);

    step(); ex_memread = 1'b1; ex_rt = 5'd8; id_rt = 5'd8; id_rs = 5'd3;
    @(negedge clk); chk("loaduse_ctrl", 32'(ctrl), 32'(C_LOADU));
    step(); ex_rt = 5'd0; id_rt = 5'd0;
    @(negedge clk); chk("loaduse_r0", 32'(ctrl), 32'(C_NORMAL));

    // memory wait with a coincident taken branch
    step(); ex_memread = 1'b0; reset = 1'b0;
    step(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
      @(negedge clk); chk("memwait_freeze", 32'(ctrl), 32'(C_FREEZE));
      step();
    end
    dmem_ready = 1'b1;
    @(negedge clk); chk("ready_branch", 32'(ctrl), 32'(C_BRANCH));
    step(); mem_req = 1'b0; branch_taken = 1'b0;
    @(negedge clk); chk("memwait_stall", 32'(stall_cycles), (PERF != 0) ? 3 : 0);

    // timeout into ERR
    step(); reset = 1'b0;
    step(); reset = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("timeout_err_low", 32'(mem_err), 0);
      step();
    end
    mem_req = 1'b0; dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_sticky", 32'(mem_err), 1);
      chk("err_freeze", 32'(ctrl), 32'(C_FREEZE));
      step();
    end
    reset = 1'b0;
    @(negedge clk); chk("err_reset", 32'(mem_err), 0);
    step(); reset = 1'b1;
    @(negedge clk); chk("err_recover", 32'(ctrl), 32'(C_NORMAL));

    // counter saturation over a long freeze
    step(); mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 22; i++) step();
    @(negedge clk); chk("stall_saturate", 32'(stall_cycles), (PERF != 0) ? STALL_MAX : 0);

    for (int i = 0; i < 3000; i++) begin
      step();
      reset        = ($urandom_range(0, 63) != 0);
      mem_req      = ($urandom_range(0, 1) != 0);
      dmem_ready   = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      ex_memread   = ($urandom_range(0, 1) != 0);
      ex_rt        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
    end
    step(); reset = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
